rot_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle combinational log-shifter rotator.
- Rotates or logically shifts an N-bit word by a runtime amount, in either direction.
- Pipeline registers are inserted every STAGES_PER_REG log-stages.
- Uses a valid/ready handshake with full backpressure; sits between datapath FIFOs in the bit-permutation datapath.

---
 rtl/rot_pkg.sv | 20 ++
 rtl/rot_pipe_seg.sv | 40 ++++
 rtl/rot_pipe.sv | 136 +++++++++++++
 tb/tb_rot_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and helpers for the pipelined rotator/shifter (rot_pipe).
// Direction/mode encodings travel with each beat down the pipe.
package rot_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_ROT   = 1'b0,
        MODE_SHIFT = 1'b1
    } mode_e;

    // Number of register slots: ceil(log2_n / stages_per_reg).
    function automatic int rot_latency(input int log2_n, input int stages_per_reg);
        return (log2_n + stages_per_reg - 1) / stages_per_reg;
    endfunction

endpackage

// File: rtl/rot_pipe_seg.sv
// Combinational run of COUNT log-shifter stages starting at stage FIRST.
// Stage s moves the word by N>>(s+1) positions when its amount bit is set.
module rot_pipe_seg
    import rot_pkg::*;
#(
    parameter int N     = 4096,
    parameter int FIRST = 0,
    parameter int COUNT = 3
) (
    input  logic [0:N-1]       d_in,
    input  logic [COUNT-1:0]   amt_bits,
    input  dir_e               dir,
    input  mode_e              mode,
    output logic [0:N-1]       d_out
);

    logic [0:N-1] chain [COUNT+1];

    assign chain[0] = d_in;

    for (genvar g = 0; g < COUNT; g++) begin : g_stage
        localparam int K = N >> (FIRST + g + 1);

        logic [0:N-1] up_word;
        logic [0:N-1] down_word;

        // Index 0 is the MSB, so >> moves bits toward higher index.
        assign up_word   = (chain[g] >> K)
                         | ((mode == MODE_ROT) ? (chain[g] << (N - K)) : '0);
        assign down_word = (chain[g] << K)
                         | ((mode == MODE_ROT) ? (chain[g] >> (N - K)) : '0);

        assign chain[g+1] = !amt_bits[COUNT-1-g] ? chain[g]
                          : (dir == DIR_UP)       ? up_word
                          :                         down_word;
    end

    assign d_out = chain[COUNT];

endmodule

// File: rtl/rot_pipe.sv
// Pipelined N-bit rotator / logical shifter with valid/ready backpressure.
// Optional carried-parity check enabled by defining ROT_PIPE_PARITY_EN.
module rot_pipe
    import rot_pkg::*;
#(
    parameter int N              = 4096,
    parameter int LOG2_N         = 12,
    parameter int STAGES_PER_REG = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:N-1]      in_data,
    input  logic [LOG2_N-1:0] in_amt,
    input  logic              in_dir,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:N-1]      out_data
`ifdef ROT_PIPE_PARITY_EN
    ,
    input  logic              in_par,
    output logic              par_err
`endif
);

    localparam int L = rot_latency(LOG2_N, STAGES_PER_REG);

    // Remaining amount bits are kept left-aligned; each segment consumes the top ones.
    typedef struct packed {
        logic [0:N-1]      data;
        logic [LOG2_N-1:0] amt;
        dir_e              dir;
        mode_e             mode;
`ifdef ROT_PIPE_PARITY_EN
        logic              par;
`endif
    } slot_t;

    function automatic slot_t step_slot(input slot_t s, input logic [0:N-1] d, input int cnt);
        slot_t r;
        r      = s;
        r.data = d;
        r.amt  = s.amt << cnt;
        return r;
    endfunction

    slot_t        slot_q    [L];
    slot_t        seg_in    [L];
    slot_t        next_slot [L];
    logic [L-1:0] valid_q;
    logic [L-1:0] src_valid;
    logic [L:0]   ready;

    assign seg_in[0].data = in_data;
    assign seg_in[0].amt  = in_amt;
    assign seg_in[0].dir  = dir_e'(in_dir);
    assign seg_in[0].mode = mode_e'(in_mode);
`ifdef ROT_PIPE_PARITY_EN
    assign seg_in[0].par  = in_par;
`endif

    for (genvar j = 0; j < L; j++) begin : g_seg
        localparam int FIRST = j * STAGES_PER_REG;
        localparam int CNT   = (FIRST + STAGES_PER_REG > LOG2_N) ? (LOG2_N - FIRST)
                                                                 : STAGES_PER_REG;
        logic [0:N-1] seg_data;

        if (j > 0) begin : g_link
            assign seg_in[j] = slot_q[j-1];
        end

        rot_pipe_seg #(
            .N     (N),
            .FIRST (FIRST),
            .COUNT (CNT)
        ) u_seg (
            .d_in     (seg_in[j].data),
            .amt_bits (seg_in[j].amt[LOG2_N-1 -: CNT]),
            .dir      (seg_in[j].dir),
            .mode     (seg_in[j].mode),
            .d_out    (seg_data)
        );

        assign next_slot[j] = step_slot(seg_in[j], seg_data, CNT);
    end

    // A slot can load when it is empty or its occupant leaves this cycle.
    always_comb begin
        ready[L]     = out_ready;
        src_valid[0] = in_valid;
        for (int j = L - 1; j >= 0; j--) begin
            ready[j] = ~valid_q[j] | ready[j+1];
        end
        for (int j = 1; j < L; j++) begin
            src_valid[j] = valid_q[j-1];
        end
    end

    // NOTE: payload registers are reset too, so out_data can never show X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int j = 0; j < L; j++) begin
                slot_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < L; j++) begin
                if (ready[j]) begin
                    valid_q[j] <= src_valid[j];
                    if (src_valid[j]) begin
                        slot_q[j] <= next_slot[j];
                    end
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[L-1];
    assign out_data  = slot_q[L-1].data;

`ifdef ROT_PIPE_PARITY_EN
    // Rotation preserves parity; shifting drops bits, so only rotate beats are checked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (out_valid && out_ready && (slot_q[L-1].mode == MODE_ROT)
                     && ((^slot_q[L-1].data) != slot_q[L-1].par)) begin
            par_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rot_pipe.sv
// Directed self-checking bench for rot_pipe at N=8, one mux stage per slot (latency 3).
// Also exercises the parity checker when ROT_PIPE_PARITY_EN is defined.
module tb_rot_pipe;

    localparam int N   = 8;
    localparam int LG  = 3;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [0:N-1]  in_data;
    logic [LG-1:0] in_amt;
    logic          in_dir;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [0:N-1]  out_data;
`ifdef ROT_PIPE_PARITY_EN
    logic          in_par;
    logic          par_err;
`endif

    int checks = 0;
    int errors = 0;

    rot_pipe #(
        .N              (N),
        .LOG2_N         (LG),
        .STAGES_PER_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef ROT_PIPE_PARITY_EN
        ,
        .in_par    (in_par),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:N-1]  d;
        logic [LG-1:0] a;
        logic          dir;
        logic          mode;
        logic [0:N-1]  exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference straight from the index formulas (index 0 is the MSB).
    function automatic logic [0:N-1] model(input logic [0:N-1] d, input int a,
                                           input logic dir, input logic mode);
        logic [0:N-1] r;
        for (int i = 0; i < N; i++) begin
            int src;
            src = dir ? i + a : i - a;
            if (src >= 0 && src < N) r[i] = d[src];
            else if (mode)           r[i] = 1'b0;
            else                     r[i] = d[(src + N) % N];
        end
        return r;
    endfunction

    task automatic drive(input logic [0:N-1] d, input logic [LG-1:0] a,
                         input logic dir, input logic mode, input logic par_flip);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_dir   = dir;
        in_mode  = mode;
`ifdef ROT_PIPE_PARITY_EN
        in_par   = (^d) ^ par_flip;
`else
        if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    endtask

    // One isolated beat: checks acceptance, exact latency, result, and single emission.
    task automatic run_single(input string name, input logic [0:N-1] d, input logic [LG-1:0] a,
                              input logic dir, input logic mode, input logic [0:N-1] exp,
                              input logic par_flip);
        int n;
        @(negedge clk);
        drive(d, a, dir, mode, par_flip);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(LAT));
        check({name, "_data"}, 64'(out_data), 64'(exp));
        @(negedge clk);
        check({name, "_single"}, 64'(out_valid), 64'd0);
    endtask

    vec_t          vecs [11];
    logic [0:N-1]  exp_q [$];
    logic [0:N-1]  exp_d;
    logic [0:N-1]  cap;
    logic [0:N-1]  sd;
    int            sent, got, cyc, first, last, acc;
    logic          have_cap, stale;

    initial begin
        vecs[0]  = '{8'b1000_0001, 3'd1, 1'b0, 1'b0, 8'b1100_0000};
        vecs[1]  = '{8'b1011_0110, 3'd3, 1'b1, 1'b1, 8'b1011_0000};
        vecs[2]  = '{8'b1011_0110, 3'd0, 1'b0, 1'b0, 8'b1011_0110};
        vecs[3]  = '{8'b1011_0110, 3'd0, 1'b1, 1'b1, 8'b1011_0110};
        vecs[4]  = '{8'b1011_0110, 3'd7, 1'b0, 1'b1, 8'b0000_0001};
        vecs[5]  = '{8'b0110_1101, 3'd7, 1'b1, 1'b1, 8'b1000_0000};
        vecs[6]  = '{8'b1011_0110, 3'd2, 1'b1, 1'b0, 8'b1101_1010};
        vecs[7]  = '{8'b1011_0110, 3'd5, 1'b0, 1'b0, 8'b1011_0101};
        vecs[8]  = '{8'b1111_0000, 3'd4, 1'b0, 1'b1, 8'b0000_1111};
        vecs[9]  = '{8'b1000_0001, 3'd1, 1'b1, 1'b1, 8'b0000_0010};
        vecs[10] = '{8'b0000_0001, 3'd7, 1'b0, 1'b0, 8'b0000_0010};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].dir,
                       vecs[i].mode, vecs[i].exp, 1'b0);
        end

        // Back-to-back stream of 16 beats, amount cycling 0..7.
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; first = -1; last = -1;
        while (got < 16 && cyc < 60) begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 64'(out_valid), 64'd0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("stream_data", 64'(out_data), 64'(exp_d));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (sent < 16) begin
                sd = 8'($urandom);
                drive(sd, 3'(sent % 8), sent[0] ^ sent[3], sent[1], 1'b0);
                check("stream_in_ready", 64'(in_ready), 64'd1);
                exp_q.push_back(model(sd, sent % 8, sent[0] ^ sent[3], sent[1]));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        check("stream_count", 64'(got), 64'd16);
        check("stream_no_gaps", 64'(last - first), 64'd15);

        // Backpressure: out_ready low for 6 cycles with in_valid held high.
        @(negedge clk);
        exp_q.delete();
        out_ready = 1'b0;
        acc = 0;
        have_cap = 1'b0;
        cap = '0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                if (!have_cap) begin
                    cap = out_data;
                    have_cap = 1'b1;
                end else begin
                    check("stall_hold", 64'(out_data), 64'(cap));
                end
            end
            sd = 8'h11 << acc;
            drive(sd, 3'(acc + 1), 1'b0, 1'b0, 1'b0);
            if (in_ready) begin
                exp_q.push_back(model(sd, acc + 1, 1'b0, 1'b0));
                acc++;
            end
        end
        check("stall_accepted", 64'(acc), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_first_beat", 64'(cap), 64'(exp_q[0]));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_duplicate", 64'(out_valid), 64'd0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("drain_data", 64'(out_data), 64'(exp_d));
                end
                got++;
            end
            @(negedge clk);
        end
        check("drain_count", 64'(got), 64'd3);

        // Asynchronous reset while beats are in flight and the output is stalled.
        out_ready = 1'b0;
        drive(8'b1000_0001, 3'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'b0100_0010, 3'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        check("pre_reset_data", 64'(out_data), 64'(8'b1100_0000));
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        check("async_reset_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("reset_release_in_ready", 64'(in_ready), 64'd1);
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            stale = stale | out_valid;
            @(negedge clk);
        end
        check("no_stale_beats", 64'(stale), 64'd0);

`ifdef ROT_PIPE_PARITY_EN
        run_single("par_shift", 8'b1011_0110, 3'd2, 1'b0, 1'b1, 8'b0010_1101, 1'b1);
        check("par_shift_no_err", 64'(par_err), 64'd0);
        run_single("par_rot", 8'b1000_0001, 3'd1, 1'b0, 1'b0, 8'b1100_0000, 1'b1);
        check("par_rot_err", 64'(par_err), 64'd1);
        run_single("par_good", 8'b1000_0001, 3'd1, 1'b0, 1'b0, 8'b1100_0000, 1'b0);
        check("par_sticky", 64'(par_err), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
